// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV64I-subset opcodes, ALU codes and size codes
package riscv_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       jal;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] alu_op;
    logic       alu_src;
    logic [1:0] mem_size;
    logic [1:0] load_size;
  } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x64 register file, two bypassed read ports, one write port
module reg_file
  import riscv_pkg::*;
(
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != 5'd0);

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Same-cycle writeback is forwarded so decode never sees a stale value.
  always_comb begin
    rd1_o = '0;
    if (rs1_i != 5'd0) rd1_o = (wr_en && waddr_i == rs1_i) ? wdata_i : regs_q[rs1_i];
  end

  always_comb begin
    rd2_o = '0;
    if (rs2_i != 5'd0) rd2_o = (wr_en && waddr_i == rs2_i) ? wdata_i : regs_q[rs2_i];
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: control decode, immediates, branch resolve, ID/EX register
module decode_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteEnW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  output logic            RegWriteEnE,
  output logic            MemtoRegE,
  output logic            JALE,
  output logic            MemReadEnE,
  output logic            MemWriteEnE,
  output logic [2:0]      ALUOpE,
  output logic            ALUSrcE,
  output logic [1:0]      MemSizeE,
  output logic [1:0]      LoadSizeE,
  output logic            PCSF,
  output logic [XLEN-1:0] ImmE,
  output logic [4:0]      RdE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [XLEN-1:0] ReadData1E,
  output logic [XLEN-1:0] ReadData2E,
  output logic [XLEN-1:0] PCTargetD
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];

  logic [XLEN-1:0] rs1_val, rs2_val;

  reg_file u_reg_file (
    .clk_i    (clk),
    .resetn_i (rst),
    .rs1_i    (InstrD[19:15]),
    .rs2_i    (InstrD[24:20]),
    .rd1_o    (rs1_val),
    .rd2_o    (rs2_val),
    .we_i     (RegWriteEnW),
    .waddr_i  (RDW),
    .wdata_i  (ResultW)
  );

  ctrl_t      ctrl_d;
  logic       is_beq, is_bne, is_jal, is_jalr, is_lui;
  logic       op_ok;
  logic [2:0] op_sel;

  always_comb begin
    ctrl_d  = '0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    is_lui  = 1'b0;
    op_ok   = 1'b0;
    op_sel  = ALU_ADD;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000) begin
          op_ok = 1'b1;
          case (funct3)
            3'b000:  op_sel = ALU_ADD;
            3'b111:  op_sel = ALU_AND;
            3'b110:  op_sel = ALU_OR;
            3'b100:  op_sel = ALU_XOR;
            3'b010:  op_sel = ALU_SLT;
            3'b001:  op_sel = ALU_SLL;
            3'b101:  op_sel = ALU_SRL;
            default: op_ok  = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          op_ok  = 1'b1;
          op_sel = ALU_SUB;
        end
        ctrl_d.reg_write = op_ok;
        ctrl_d.alu_op    = op_ok ? op_sel : ALU_ADD;
      end
      OP_IMM: begin
        op_ok = 1'b1;
        case (funct3)
          3'b000:  op_sel = ALU_ADD;
          3'b111:  op_sel = ALU_AND;
          3'b110:  op_sel = ALU_OR;
          default: op_ok  = 1'b0;
        endcase
        ctrl_d.reg_write = op_ok;
        ctrl_d.alu_src   = op_ok;
        ctrl_d.alu_op    = op_ok ? op_sel : ALU_ADD;
      end
      OP_LOAD: begin
        if (funct3 == 3'b001 || funct3 == 3'b010) begin
          ctrl_d.reg_write  = 1'b1;
          ctrl_d.mem_to_reg = 1'b1;
          ctrl_d.mem_read   = 1'b1;
          ctrl_d.alu_src    = 1'b1;
          ctrl_d.load_size  = (funct3 == 3'b001) ? SZ_HALF : SZ_WORD;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b000 || funct3 == 3'b010) begin
          ctrl_d.mem_write = 1'b1;
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.mem_size  = (funct3 == 3'b000) ? SZ_BYTE : SZ_WORD;
        end
      end
      OP_BRANCH: begin
        is_beq = (funct3 == 3'b000);
        is_bne = (funct3 == 3'b001);
        if (is_beq || is_bne) ctrl_d.alu_op = ALU_SUB;
      end
      OP_JAL: begin
        is_jal           = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.jal       = 1'b1;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          is_jalr          = 1'b1;
          ctrl_d.reg_write = 1'b1;
          ctrl_d.jal       = 1'b1;
          ctrl_d.alu_src   = 1'b1;
        end
      end
      OP_LUI: begin
        is_lui           = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
      end
      default: ;
    endcase
  end

  // Format follows the opcode alone, so bubbles still carry a decoded immediate.
  logic [XLEN-1:0] imm_d;
  always_comb begin
    case (opcode)
      OP_STORE:  imm_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      OP_BRANCH: imm_d = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                          InstrD[11:8], 1'b0};
      OP_JAL:    imm_d = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                          InstrD[30:21], 1'b0};
      OP_LUI:    imm_d = {{(XLEN-32){InstrD[31]}}, InstrD[31:12], 12'b0};
      default:   imm_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
    endcase
  end

  logic rs_equal;
  assign rs_equal  = (rs1_val == rs2_val);
  assign PCTargetD = is_jalr ? ((rs1_val + imm_d) & {{(XLEN-1){1'b1}}, 1'b0}) : (PCD + imm_d);
  assign PCSF      = rst & (is_jal | is_jalr | (is_beq & rs_equal) | (is_bne & ~rs_equal));

  ctrl_t           ctrl_q;
  logic [XLEN-1:0] imm_q, pcp4_q, rd1_q, rd2_q, rd1_d;
  logic [4:0]      rd_q;

  assign rd1_d = is_lui ? '0 : rs1_val;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q <= '0;
      imm_q  <= '0;
      rd_q   <= '0;
      pcp4_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      imm_q  <= imm_d;
      rd_q   <= InstrD[11:7];
      pcp4_q <= PCPlus4D;
      rd1_q  <= rd1_d;
      rd2_q  <= rs2_val;
    end
  end

  assign RegWriteEnE = ctrl_q.reg_write;
  assign MemtoRegE   = ctrl_q.mem_to_reg;
  assign JALE        = ctrl_q.jal;
  assign MemReadEnE  = ctrl_q.mem_read;
  assign MemWriteEnE = ctrl_q.mem_write;
  assign ALUOpE      = ctrl_q.alu_op;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign MemSizeE    = ctrl_q.mem_size;
  assign LoadSizeE   = ctrl_q.load_size;
  assign ImmE        = imm_q;
  assign RdE         = rd_q;
  assign PCPlus4E    = pcp4_q;
  assign ReadData1E  = rd1_q;
  assign ReadData2E  = rd2_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage with a mnemonic-level model
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD;
  logic [63:0] PCD, PCPlus4D, ResultW;
  logic        RegWriteEnW;
  logic [4:0]  RDW;
  logic        RegWriteEnE, MemtoRegE, JALE, MemReadEnE, MemWriteEnE, ALUSrcE, PCSF;
  logic [2:0]  ALUOpE;
  logic [1:0]  MemSizeE, LoadSizeE;
  logic [63:0] ImmE, PCPlus4E, ReadData1E, ReadData2E, PCTargetD;
  logic [4:0]  RdE;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteEnW(RegWriteEnW), .RDW(RDW), .ResultW(ResultW),
    .RegWriteEnE(RegWriteEnE), .MemtoRegE(MemtoRegE), .JALE(JALE),
    .MemReadEnE(MemReadEnE), .MemWriteEnE(MemWriteEnE), .ALUOpE(ALUOpE),
    .ALUSrcE(ALUSrcE), .MemSizeE(MemSizeE), .LoadSizeE(LoadSizeE), .PCSF(PCSF),
    .ImmE(ImmE), .RdE(RdE), .PCPlus4E(PCPlus4E), .ReadData1E(ReadData1E),
    .ReadData2E(ReadData2E), .PCTargetD(PCTargetD)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef enum {
    M_BUB, M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLT, M_SLL, M_SRL,
    M_ADDI, M_ANDI, M_ORI, M_LH, M_LW, M_SB, M_SW, M_BEQ, M_BNE, M_JAL, M_JALR, M_LUI
  } mn_t;

  typedef struct packed {
    logic        rw, m2r, jal, mrd, mwr;
    logic [2:0]  aluop;
    logic        asrc;
    logic [1:0]  msz, lsz;
    logic [63:0] imm;
    logic        immc;
    logic [4:0]  rd;
    logic [63:0] pcp4, rd1, rd2;
    logic        pcsf;
    logic [63:0] tgt;
  } exp_t;

  // Disassembler-style mask/match classification.
  function automatic mn_t classify(input logic [31:0] ins);
    case (ins & 32'hFE00707F)
      32'h00000033: return M_ADD;
      32'h40000033: return M_SUB;
      32'h00007033: return M_AND;
      32'h00006033: return M_OR;
      32'h00004033: return M_XOR;
      32'h00002033: return M_SLT;
      32'h00001033: return M_SLL;
      32'h00005033: return M_SRL;
      default: ;
    endcase
    case (ins & 32'h0000707F)
      32'h00000013: return M_ADDI;
      32'h00007013: return M_ANDI;
      32'h00006013: return M_ORI;
      32'h00001003: return M_LH;
      32'h00002003: return M_LW;
      32'h00000023: return M_SB;
      32'h00002023: return M_SW;
      32'h00000063: return M_BEQ;
      32'h00001063: return M_BNE;
      32'h00000067: return M_JALR;
      default: ;
    endcase
    if (ins[6:0] == 7'h6F) return M_JAL;
    if (ins[6:0] == 7'h37) return M_LUI;
    return M_BUB;
  endfunction

  function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
    logic signed [63:0] t;
    t = v << (64 - bits);
    return t >>> (64 - bits);
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc, pcp4, a, b);
    exp_t e;
    mn_t  m;
    e = '0;
    m = classify(ins);
    e.rd   = ins[11:7];
    e.pcp4 = pcp4;
    e.rd1  = (m == M_LUI) ? 64'd0 : a;
    e.rd2  = b;
    case (ins[6:0])
      7'h23: e.imm = sext({52'd0, ins[31:25], ins[11:7]}, 12);
      7'h63: e.imm = sext({51'd0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
      7'h6F: e.imm = sext({43'd0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
      7'h37: e.imm = sext({44'd0, ins[31:12]}, 20) << 12;
      default: e.imm = sext({52'd0, ins[31:20]}, 12);
    endcase
    e.immc = (ins[6:0] inside {7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37});
    case (m)
      M_ADD: begin e.rw = 1; e.aluop = 3'd0; end
      M_SUB: begin e.rw = 1; e.aluop = 3'd1; end
      M_AND: begin e.rw = 1; e.aluop = 3'd2; end
      M_OR:  begin e.rw = 1; e.aluop = 3'd3; end
      M_XOR: begin e.rw = 1; e.aluop = 3'd4; end
      M_SLT: begin e.rw = 1; e.aluop = 3'd5; end
      M_SLL: begin e.rw = 1; e.aluop = 3'd6; end
      M_SRL: begin e.rw = 1; e.aluop = 3'd7; end
      M_ADDI: begin e.rw = 1; e.asrc = 1; e.aluop = 3'd0; end
      M_ANDI: begin e.rw = 1; e.asrc = 1; e.aluop = 3'd2; end
      M_ORI:  begin e.rw = 1; e.asrc = 1; e.aluop = 3'd3; end
      M_LH: begin e.rw = 1; e.m2r = 1; e.mrd = 1; e.asrc = 1; e.lsz = 2'd1; end
      M_LW: begin e.rw = 1; e.m2r = 1; e.mrd = 1; e.asrc = 1; e.lsz = 2'd2; end
      M_SB: begin e.mwr = 1; e.asrc = 1; e.msz = 2'd0; end
      M_SW: begin e.mwr = 1; e.asrc = 1; e.msz = 2'd2; end
      M_BEQ: begin e.aluop = 3'd1; e.pcsf = (a == b); end
      M_BNE: begin e.aluop = 3'd1; e.pcsf = (a != b); end
      M_JAL:  begin e.rw = 1; e.jal = 1; e.pcsf = 1; end
      M_JALR: begin e.rw = 1; e.jal = 1; e.asrc = 1; e.pcsf = 1; end
      M_LUI:  begin e.rw = 1; e.asrc = 1; end
      default: ;
    endcase
    e.tgt = (m == M_JALR) ? ((a + e.imm) & ~64'd1) : (pc + e.imm);
    return e;
  endfunction

  logic [63:0] mregs [32];
  exp_t        exp_q;
  logic        model_ok = 1'b0;

  function automatic logic [63:0] rv(input logic [4:0] r);
    if (r == 5'd0) return 64'd0;
    if (RegWriteEnW && RDW == r) return ResultW;
    return mregs[r];
  endfunction

  function automatic exp_t reset_exp();
    exp_t z;
    z = '0;
    z.immc = 1'b1;
    return z;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      exp_q <= reset_exp();
      for (int i = 0; i < 32; i++) mregs[i] <= 64'd0;
      model_ok <= 1'b1;
    end else begin
      exp_q <= model(InstrD, PCD, PCPlus4D, rv(InstrD[19:15]), rv(InstrD[24:20]));
      if (RegWriteEnW && RDW != 5'd0) mregs[RDW] <= ResultW;
    end
  end

  always @(negedge clk) begin
    exp_t cur;
    if (model_ok) begin
      chk("RegWriteEnE", 64'(RegWriteEnE), 64'(exp_q.rw));
      chk("MemtoRegE", 64'(MemtoRegE), 64'(exp_q.m2r));
      chk("JALE", 64'(JALE), 64'(exp_q.jal));
      chk("MemReadEnE", 64'(MemReadEnE), 64'(exp_q.mrd));
      chk("MemWriteEnE", 64'(MemWriteEnE), 64'(exp_q.mwr));
      chk("ALUOpE", 64'(ALUOpE), 64'(exp_q.aluop));
      chk("ALUSrcE", 64'(ALUSrcE), 64'(exp_q.asrc));
      chk("MemSizeE", 64'(MemSizeE), 64'(exp_q.msz));
      chk("LoadSizeE", 64'(LoadSizeE), 64'(exp_q.lsz));
      if (exp_q.immc) chk("ImmE", ImmE, exp_q.imm);
      chk("RdE", 64'(RdE), 64'(exp_q.rd));
      chk("PCPlus4E", PCPlus4E, exp_q.pcp4);
      chk("ReadData1E", ReadData1E, exp_q.rd1);
      chk("ReadData2E", ReadData2E, exp_q.rd2);
      if (rst) begin
        cur = model(InstrD, PCD, PCPlus4D, rv(InstrD[19:15]), rv(InstrD[24:20]));
        chk("PCSF", 64'(PCSF), 64'(cur.pcsf));
        if (cur.immc) chk("PCTargetD", PCTargetD, cur.tgt);
      end else begin
        chk("PCSF_in_reset", 64'(PCSF), 64'd0);
      end
    end
  end

  task automatic cyc(input logic [31:0] ins, input logic [63:0] pc,
                     input logic we, input logic [4:0] rdw, input logic [63:0] res);
    @(posedge clk);
    #2;
    InstrD      = ins;
    PCD         = pc;
    PCPlus4D    = pc + 64'd4;
    RegWriteEnW = we;
    RDW         = rdw;
    ResultW     = res;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  localparam logic [31:0] MISC [15] = '{
    32'h40320333, 32'h0041A333, 32'h00419333, 32'h0041D333, 32'h0041C333,
    32'h0041E333, 32'h00418333, 32'h0041B333, 32'h02418333, 32'h0041C213,
    32'hFFFFFFFF, 32'h00318463, 32'h00319463, 32'hFF81A283, 32'h00008067
  };

  initial begin
    rst         = 1'b0;
    InstrD      = 32'h008000EF;
    PCD         = 64'h0;
    PCPlus4D    = 64'h4;
    RegWriteEnW = 1'b1;
    RDW         = 5'd5;
    ResultW     = 64'hBAD;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_RegWriteEnE", 64'(RegWriteEnE), 64'd0);
    chk("rst_ImmE", ImmE, 64'd0);
    chk("rst_PCSF_jal", 64'(PCSF), 64'd0);
    rst = 1'b1;
    RegWriteEnW = 1'b0;

    for (int i = 0; i < 32; i++) cyc(enc_r(7'd0, 5'(i), 5'(i), 3'd0, 5'd0), 64'h200 + 64'(4 * i), 0, 0, 0);

    cyc(32'h00508213, 64'h0, 0, 0, 0);
    cyc(32'h003172B3, 64'h4, 1, 5'd3, 64'd15);
    chk("addi_RegWriteEnE", 64'(RegWriteEnE), 64'd1);
    chk("addi_ALUSrcE", 64'(ALUSrcE), 64'd1);
    chk("addi_ALUOpE", 64'(ALUOpE), 64'd0);
    chk("addi_RdE", 64'(RdE), 64'd4);
    chk("addi_ImmE", ImmE, 64'd5);
    chk("addi_ReadData1E", ReadData1E, 64'd0);
    chk("addi_PCPlus4E", PCPlus4E, 64'd4);
    cyc(32'h003172B3, 64'h8, 1, 5'd4, 64'd20);
    chk("and_bypass_ALUOpE", 64'(ALUOpE), 64'd2);
    chk("and_bypass_ReadData2E", ReadData2E, 64'd15);
    cyc(32'h00218163, 64'h10, 0, 0, 0);
    chk("and_ReadData2E", ReadData2E, 64'd15);
    #1;
    chk("beq_PCTargetD", PCTargetD, 64'h12);
    chk("beq_PCSF", 64'(PCSF), 64'd0);
    cyc(32'h004190E3, 64'h14, 0, 0, 0);
    #1;
    chk("bne_PCTargetD", PCTargetD, 64'h814);
    chk("bne_PCSF", 64'(PCSF), 64'd1);
    cyc(32'h008000EF, 64'h18, 1, 5'd1, 64'h101);
    #1;
    chk("jal_PCSF", 64'(PCSF), 64'd1);
    chk("jal_PCTargetD", PCTargetD, 64'h20);
    cyc(32'h002081E7, 64'h1C, 0, 0, 0);
    chk("jal_JALE", 64'(JALE), 64'd1);
    chk("jal_RegWriteEnE", 64'(RegWriteEnE), 64'd1);
    #1;
    chk("jalr_PCTargetD", PCTargetD, 64'h102);
    chk("jalr_PCSF", 64'(PCSF), 64'd1);
    cyc(32'h00309203, 64'h20, 0, 0, 0);
    chk("jalr_ALUSrcE", 64'(ALUSrcE), 64'd1);
    cyc(32'h00B12023, 64'h24, 0, 0, 0);
    chk("lh_MemReadEnE", 64'(MemReadEnE), 64'd1);
    chk("lh_MemtoRegE", 64'(MemtoRegE), 64'd1);
    chk("lh_LoadSizeE", 64'(LoadSizeE), 64'd1);
    chk("lh_ImmE", ImmE, 64'd3);
    chk("lh_ReadData1E", ReadData1E, 64'h101);
    cyc(32'h00B10023, 64'h28, 0, 0, 0);
    chk("sw_MemWriteEnE", 64'(MemWriteEnE), 64'd1);
    chk("sw_MemSizeE", 64'(MemSizeE), 64'd2);
    chk("sw_RegWriteEnE", 64'(RegWriteEnE), 64'd0);
    cyc(32'h000010B7, 64'h2C, 0, 0, 0);
    chk("sb_MemSizeE", 64'(MemSizeE), 64'd0);
    chk("sb_MemWriteEnE", 64'(MemWriteEnE), 64'd1);
    cyc(32'h000090B7, 64'h30, 0, 0, 0);
    chk("lui_ImmE", ImmE, 64'h1000);
    chk("lui_ReadData1E", ReadData1E, 64'd0);
    cyc(32'hFFF00093, 64'h34, 0, 0, 0);
    chk("lui_rs1_forced_ReadData1E", ReadData1E, 64'd0);
    chk("lui_rs1_ImmE", ImmE, 64'h9000);
    cyc(32'hFFDFF06F, 64'h40, 0, 0, 0);
    chk("addi_neg_ImmE", ImmE, 64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    chk("jal_back_PCTargetD", PCTargetD, 64'h3C);

    for (int k = 0; k < 15; k++) cyc(MISC[k], 64'h100 + 64'(4 * k), 0, 0, 0);
    cyc(32'h00000333, 64'h140, 1, 5'd0, 64'h55);
    cyc(32'h00000333, 64'h144, 0, 0, 0);

    cyc(32'h00508213, 64'h50, 1, 5'd7, 64'hDEAD);
    @(posedge clk);
    #2;
    rst = 1'b0;
    InstrD = 32'h000010B7;
    RegWriteEnW = 1'b0;
    @(posedge clk);
    #2;
    chk("midrst_RegWriteEnE", 64'(RegWriteEnE), 64'd0);
    chk("midrst_ImmE", ImmE, 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cyc(enc_r(7'd0, 5'(i), 5'(i), 3'd0, 5'd0), 64'h300 + 64'(4 * i), 0, 0, 0);
      if (i == 8) chk("x7_cleared", ReadData1E, 64'd0);
    end
    cyc(32'h00000013, 64'h400, 0, 0, 0);
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
ID stage of the 5-stage RV64I-subset pipeline. Decodes InstrD, reads and holds the 32x64 register file (written back from WB), and generates the sign-extended immediate. Resolves branches and jumps in decode (PCSF, PCTargetD to fetch). Drives the ID/EX pipeline register (all *E outputs).

Parameters:
XLEN, 64, datapath/register width
NREGS, 32, architectural register count (x0 hardwired zero)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset (sampled on rising clk)
InstrD  in  32  instruction in decode
PCD  in  64  PC of InstrD
PCPlus4D  in  64  PCD+4
RegWriteEnW  in  1  WB register write enable
RDW  in  5  WB destination register
ResultW  in  64  WB write data
RegWriteEnE  out  1  registered: write rd
MemtoRegE  out  1  registered: WB selects load data
JALE  out  1  registered: WB selects PCPlus4 (jal/jalr)
MemReadEnE  out  1  registered: load
MemWriteEnE  out  1  registered: store
ALUOpE  out  3  registered ALU op
ALUSrcE  out  1  registered: ALU B = ImmE
MemSizeE  out  2  registered store size
LoadSizeE  out  2  registered load size
PCSF  out  1  combinational: redirect fetch to PCTargetD
ImmE  out  64  registered sign-extended immediate
RdE  out  5  registered rd
PCPlus4E  out  64  registered PCPlus4D
ReadData1E  out  64  registered rs1 value
ReadData2E  out  64  registered rs2 value
PCTargetD  out  64  combinational branch/jump target

Behaviour:
- Supported: add sub and or xor slt sll srl (0110011); addi andi ori (0010011); lh lw (0000011); sb sw (0100011); beq bne (1100011); jal (1101111); jalr (1100111); lui (0110111). Any other opcode/funct: all control bits 0 (bubble); the immediate is still decoded by format.
- ALUOp: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL. Loads, stores, jalr, lui and jal use ADD. Branches use SUB.
- Size codes for MemSizeE/LoadSizeE: 00 byte, 01 half, 10 word. MemSizeE is valid on stores and LoadSizeE on loads; each is 00 otherwise.
- Immediates: I/S/B/J formats sign-extended from bit 31. B and J immediates carry an implicit 0 LSB. U format is {sign-ext InstrD[31:12], 12'b0}.
- ALUSrcE=1 for I-type, loads, stores, jalr, lui. MemtoRegE=1 for loads. JALE=1 for jal and jalr. RegWriteEnE=1 for R, I-ALU, load, jal, jalr, lui.
- Register file: 32x64. Write on rising clk when RegWriteEnW && RDW!=0. Reads of x0 return 0.
- Read bypass: if RegWriteEnW && RDW!=0 && RDW==rs, the read returns ResultW in the same cycle.
- lui forces the rs1 read value to 0, so ADD yields the immediate.
- PCTargetD: jalr gives (rs1+imm) & ~1. All others give PCD+imm.
- PCSF conditions: jal; jalr; beq && rs1==rs2; bne && rs1!=rs2. PCSF is 0 for everything else, and 0 while rst=0.
- Latency: all *E outputs update one rising clk after InstrD/PCD are presented. PCSF and PCTargetD are same-cycle.
- Reset (rst=0 at rising clk): all *E outputs cleared to 0 and all 32 registers cleared to 0. Writeback is ignored during reset. Reset mid-stream discards the in-flight decode.
- No stall/flush inputs; the pipeline register loads every cycle.

Decomposition:
- Shared package riscv_pkg: opcode constants, ALUOp codes, size codes, XLEN.
- One sub-module, reg_file: 2 combinational read ports with WB bypass, 1 synchronous write port, x0 zero, synchronous active-low clear.
- Control decoder and immediate generator stay inline in decode_stage.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> all *E outputs 0, PCSF=0; every register then reads 0.
- addi x4,x1,5 (0x00508213) after reset -> next cycle RegWriteEnE=1, ALUSrcE=1, ALUOpE=000, RdE=4, ImmE=5, ReadData1E=0, PCPlus4E=PCPlus4D.
- Write x3=15 via WB, then and x5,x2,x3 (0x003172B3) -> ALUOpE=010, ReadData2E=15. Bypass check: present the instruction in the same cycle as the WB write -> ReadData2E=15.
- Branch: x2=0, x3=15, x4=20; beq x2,x3 (0x00218163), PCD=0x10 -> PCTargetD=0x12, PCSF=0. bne x3,x4 (0x004190E3), PCD=0x14 -> PCTargetD=0x814, PCSF=1.
- Jumps: jal x1,8 (0x008000EF), PCD=0x18 -> PCSF=1, PCTargetD=0x20; next cycle JALE=1, RegWriteEnE=1. jalr x3,2(x1) with x1=0x101 -> PCTargetD=0x102.
- Memory/lui: lh x4,3(x1) -> MemReadEnE=1, MemtoRegE=1, LoadSizeE=01, ImmE=3. sw x11,0(x2) -> MemWriteEnE=1, MemSizeE=10, RegWriteEnE=0. sb -> MemSizeE=00. lui x1,1 (0x000010B7) -> ImmE=0x1000, ReadData1E=0.
